// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: program-memory port, stall/redirect controls, and the IF/ID register outputs.
interface instr_fetch_stage_if #(
  parameter int PC_W = 16,
  parameter int IW   = 32
);
  logic            stall;
  logic            stall_pm;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pm_addr;
  logic [IW-1:0]   pm_data;
  logic [IW-1:0]   ir;
  logic [PC_W-1:0] ir_pc;
  logic            ir_valid;
  logic [5:0]      op;
  logic [7:0]      bubble_cnt;

  modport master (
    input  stall, stall_pm, branch_taken, branch_target, pm_data,
    output pm_addr, ir, ir_pc, ir_valid, op, bubble_cnt
  );

  modport slave (
    output stall, stall_pm, branch_taken, branch_target, pm_data,
    input  pm_addr, ir, ir_pc, ir_valid, op, bubble_cnt
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, reads program memory and registers the IF/ID instruction,
// inserting NOP bubbles on stall or redirect.
//
// state | meaning
// RESET | reset asserted; PC parked at RESET_PC
// FILL  | first fetch after reset
// RUN   | steady-state fetching
module instr_fetch_stage #(
  parameter int PC_W     = 16,
  parameter int IW       = 32,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_stage_if.master fif
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [7:0]      bubble_cnt_q, bubble_cnt_d;
  logic            bubble;

  // A redirect flushes the wrong-path fetch exactly like a stall bubble.
  assign bubble = fif.branch_taken | fif.stall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_FILL;
      ST_FILL:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase

    pc_d = pc_q;
    if (fif.branch_taken)
      pc_d = fif.branch_target;
    else if (!fif.stall_pm)
      pc_d = pc_q + 1'b1;

    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (bubble) begin
      ir_d       = '0;
      ir_valid_d = 1'b0;
    end else if (!fif.stall_pm) begin
      ir_d       = fif.pm_data;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end

    bubble_cnt_d = bubble_cnt_q;
    if (bubble && bubble_cnt_q != 8'hFF)
      bubble_cnt_d = bubble_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      pc_q         <= RESET_PC_V;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      bubble_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fif.pm_addr    = pc_q;
  assign fif.ir         = ir_q;
  assign fif.ir_pc      = ir_pc_q;
  assign fif.ir_valid   = ir_valid_q;
  assign fif.op         = ir_q[IW-1 -: 6];
  assign fif.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random traffic, checked against a
// behavioural pipeline model after every clock edge.
module tb_instr_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  logic hash_mode = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state
  int unsigned m_pc;
  logic [31:0] m_ir;
  int unsigned m_ir_pc;
  logic        m_valid;
  int unsigned m_bub;

  always #5 clk = ~clk;

  instr_fetch_stage_if #(.PC_W(16), .IW(32)) bus ();

  instr_fetch_stage #(.PC_W(16), .IW(32), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a, input logic hm);
    logic [15:0] p;
    p = a * 16'd7;
    if (hm) return {a ^ 16'hA5C3, p};
    return 32'h1000_0000 + {16'h0, a};
  endfunction

  assign bus.pm_data = mem_word(bus.pm_addr, hash_mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pm_addr", {16'h0, bus.pm_addr}, m_pc);
    chk("ir", bus.ir, m_ir);
    chk("ir_pc", {16'h0, bus.ir_pc}, m_ir_pc);
    chk("ir_valid", {31'h0, bus.ir_valid}, {31'h0, m_valid});
    chk("op", {26'h0, bus.op}, m_ir >> 26);
    chk("bubble_cnt", {24'h0, bus.bubble_cnt}, m_bub);
  endtask

  // One clock edge: drive inputs, advance the model, compare every output.
  task automatic cycle(input logic rst, input logic st, input logic spm,
                       input logic br, input logic [15:0] tgt);
    logic [31:0] fetched;
    reset             = rst;
    bus.stall         = st;
    bus.stall_pm      = spm;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    fetched = mem_word(16'(m_pc), hash_mode);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_bub = 0;
    end else begin
      if (br || st) begin
        m_ir = 0; m_valid = 0;
        if (m_bub < 255) m_bub++;
      end else if (!spm) begin
        m_ir = fetched; m_ir_pc = m_pc; m_valid = 1;
      end
      if (br) m_pc = tgt;
      else if (!spm) m_pc = (m_pc + 1) % 65536;
    end
    chk_all();
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_bub = 0;
    reset = 1'b1;
    bus.stall = 0; bus.stall_pm = 0; bus.branch_taken = 0; bus.branch_target = '0;

    // Reset state
    cycle(1, 0, 0, 0, 16'h0);
    cycle(1, 0, 0, 0, 16'h0);

    // Free run: first fetch, then second
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_first_ir", bus.ir, 32'h1000_0000);
    chk("tp_first_valid", {31'h0, bus.ir_valid}, 32'h1);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_second_ir_pc", {16'h0, bus.ir_pc}, 32'h1);
    chk("tp_second_op", {26'h0, bus.op}, 32'h4);
    repeat (3) cycle(0, 0, 0, 0, 16'h0);
    chk("tp_pc5", {16'h0, bus.pm_addr}, 32'h5);

    // stall + stall_pm for two cycles at PC=5
    repeat (2) cycle(0, 1, 1, 0, 16'h0);
    chk("tp_hold_pc5", {16'h0, bus.pm_addr}, 32'h5);
    chk("tp_bub2", {24'h0, bus.bubble_cnt}, 32'h2);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_refetch5", bus.ir, 32'h1000_0005);
    repeat (2) cycle(0, 0, 0, 0, 16'h0);

    // stall_pm alone at PC=8
    cycle(0, 0, 1, 0, 16'h0);
    chk("tp_hold_pc8", {16'h0, bus.pm_addr}, 32'h8);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_load8", {16'h0, bus.ir_pc}, 32'h8);

    // stall then no stall_pm: slot kill, PC advances
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 0, 0, 0, 16'h0);

    // Redirect during stall_pm wins
    cycle(0, 0, 1, 1, 16'h0040);
    chk("tp_br_addr", {16'h0, bus.pm_addr}, 32'h40);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_br_ir_pc", {16'h0, bus.ir_pc}, 32'h40);

    // PC wrap
    cycle(0, 0, 0, 1, 16'hFFFF);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_wrap_ffff", {16'h0, bus.ir_pc}, 32'hFFFF);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_wrap_0", {16'h0, bus.ir_pc}, 32'h0);

    // Random traffic with a scrambled memory image
    hash_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic r, s, sp, b;
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 9) == 0);
      cycle(r, s, sp, b, 16'($urandom_range(0, 65535)));
    end

    // Saturation then reset mid-stream
    hash_mode = 1'b0;
    cycle(1, 0, 0, 0, 16'h0);
    repeat (300) cycle(0, 1, $urandom_range(0, 1) == 1, 0, 16'h0);
    chk("tp_sat", {24'h0, bus.bubble_cnt}, 32'hFF);
    cycle(1, 1, 1, 1, 16'h1234);
    chk("tp_rst_addr", {16'h0, bus.pm_addr}, 32'h0);
    chk("tp_rst_bub", {24'h0, bus.bubble_cnt}, 32'h0);
    chk("tp_rst_valid", {31'h0, bus.ir_valid}, 32'h0);
    cycle(0, 0, 0, 0, 16'h0);
    chk("tp_refill", bus.ir, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage of the 16-bit MIPS pipeline, directly upstream of the stall control block. It owns the program counter, addresses program memory, and registers the fetched instruction into the IF/ID instruction register (IR). It presents the IR opcode to the stall control block and consumes that block's `stall` / `stall_pm` outputs to freeze the PC and insert NOP bubbles. It also takes branch/jump redirects from decode, flushing the wrong-path instruction.

## Interface
- `PC_W`, 16, program-counter / program-memory address width (word addressed)
- `IW`, 32, instruction width; opcode is the top 6 bits
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  from stall control: load a NOP bubble into IR this cycle
- `stall_pm`  in  1  from stall control: hold PC (program memory re-reads same address)
- `branch_taken`  in  1  redirect request from decode
- `branch_target`  in  PC_W  redirect address, valid with `branch_taken`
- `pm_addr`  out  PC_W  program-memory read address (= PC register)
- `pm_data`  in  IW  program-memory read data, combinational from `pm_addr`
- `ir`  out  IW  registered instruction to decode
- `ir_pc`  out  PC_W  address of the instruction held in `ir`
- `ir_valid`  out  1  `ir` holds a real fetched instruction (0 = bubble)
- `op`  out  6  `ir[IW-1:IW-6]`, feeds the stall control block's `op`
- `bubble_cnt`  out  8  saturating count of bubbles inserted since reset

## Operation
- NOP encoding: all-zero instruction (opcode 000000).
- FSM states: RESET, FILL, RUN.
  - RESET: entered whenever `reset`=1. Goes to FILL on the first edge with `reset`=0.
  - FILL: first fetch after reset. IR loads `pm_data`, unless stall/redirect rules override. Goes to RUN.
  - RUN: steady state. Only `reset` leaves it.
- PC update priority, evaluated each edge: `reset` > `branch_taken` > `stall_pm` > increment.
  - `reset`: PC <= RESET_PC.
  - `branch_taken`: PC <= `branch_target`.
  - `stall_pm`: PC holds.
  - Otherwise: PC <= PC+1, modulo 2^PC_W (wraps from all-ones to 0).
- IR update priority: `reset` > `branch_taken` > `stall` > `stall_pm` > load.
  - `reset`: ir <= NOP, ir_pc <= 0, ir_valid <= 0.
  - `branch_taken`: ir <= NOP, ir_valid <= 0 (wrong-path flush); ir_pc holds.
  - `stall`: ir <= NOP, ir_valid <= 0; ir_pc holds.
  - `stall_pm` alone: ir, ir_pc and ir_valid hold.
  - Load: ir <= `pm_data`, ir_pc <= PC, ir_valid <= 1.
- Combined inputs:
  - `stall`=1 with `stall_pm`=1: bubble inserted and PC held; the instruction is re-fetched later.
  - `stall`=1 with `stall_pm`=0: bubble inserted and PC advances; the fetched instruction is discarded on purpose (post-jump slot kill).
- `bubble_cnt`:
  - Increments by 1 on every edge where IR is loaded with a NOP due to `stall` or `branch_taken` (not reset).
  - Saturates at 255.
  - Cleared to 0 by reset.
- `op` is combinational from the `ir` register only; there is no path from `pm_data` to `op`.

## Timing
- Reset values: pm_addr=RESET_PC, ir=0, ir_pc=0, ir_valid=0, op=000000, bubble_cnt=0, state=RESET.
- Fetch latency: the instruction at address A appears on `ir` one edge after the cycle in which pm_addr=A.
- `stall`, `stall_pm` and `branch_taken` are sampled at the same edge and take effect on that edge.
- Combinational paths:
  - `pm_data` to the `ir` D input.
  - `stall`/`stall_pm` to the PC and IR enables.
  - There is no combinational path from stall inputs to `op`, so the loop through stall control is broken by the IR register.
- Reset mid-run overrides all other inputs on that edge. The following edge behaves as FILL at RESET_PC.
- A redirect arriving during `stall_pm` wins: PC loads the target and IR is flushed.

## Test plan
- Reset, then run freely with pm_data = 0x1000_0000+addr → after the first clock with reset=0, ir=0x1000_0000, ir_pc=0, ir_valid=1; next edge ir_pc=1, op=000100.
- At PC=5, assert stall=1 and stall_pm=1 for 2 cycles → pm_addr stays 5; ir=0 and ir_valid=0 for 2 cycles; bubble_cnt=2; then ir_pc=5 with the address-5 instruction.
- At PC=8, assert stall_pm=1 alone for 1 cycle → pm_addr stays 8, ir/ir_pc/ir_valid unchanged; next edge loads the address-8 instruction.
- branch_taken=1 with target 0x0040, simultaneous with stall_pm=1 → pm_addr=0x0040, ir=NOP, ir_valid=0; next edge ir_pc=0x0040.
- Preload PC to 0xFFFF via branch, run 2 cycles → ir_pc=0xFFFF, then 0x0000 (wrap).
- Assert stall for 300 consecutive cycles → bubble_cnt=255; assert reset mid-stream → all outputs return to reset values on that edge.
